// File: rtl/jpeg_dct_pkg.sv
// Shared types and default sizing for the DCT MAC sequencer slice.
package jpeg_dct_pkg;

    localparam int DCT_TAPS     = 8;
    localparam int DCT_ROW_W    = 3;
    localparam int DCT_MULT_LAT = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } seq_state_e;

    // Accumulator strobe pair carried alongside the multiplier pipeline.
    typedef struct packed {
        logic en;
        logic clr;
    } strobe_t;

endpackage

// File: rtl/dct_mac_sequencer_if.sv
// Request/issue/accumulate/result bundle between a MAC unit and its sequencer.
interface dct_mac_sequencer_if #(
    parameter int TAPS  = 8,
    parameter int ROW_W = 3
);
    localparam int TAP_W = $clog2(TAPS);

    logic                   req_valid;
    logic [ROW_W-1:0]       req_row;
    logic                   req_ready;
    logic                   iss_en;
    logic [TAP_W-1:0]       iss_tap;
    logic [ROW_W+TAP_W-1:0] coef_addr;
    logic                   acc_en;
    logic                   acc_clr;
    logic                   res_valid;
    logic                   res_ready;
    logic                   busy;

    modport master (
        output req_valid, req_row, res_ready,
        input  req_ready, iss_en, iss_tap, coef_addr, acc_en, acc_clr, res_valid, busy
    );

    modport slave (
        input  req_valid, req_row, res_ready,
        output req_ready, iss_en, iss_tap, coef_addr, acc_en, acc_clr, res_valid, busy
    );

endinterface

// File: rtl/dct_strobe_delay.sv
// Purpose: DEPTH-stage shift register aligning {en,clr} with the multiplier product.
// Latency: DEPTH cycles (counted in ena-qualified edges).
// Backpressure: none; ena=0 freezes every stage, clr flushes all stages.
module dct_strobe_delay
    import jpeg_dct_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    clr,
    input  logic    ena,
    input  strobe_t din,
    output strobe_t dout
);

    strobe_t pipe [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else if (ena) begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/dct_mac_sequencer.sv
// Purpose: sequence TAPS coefficient multiply steps per request and strobe the accumulator.
// Latency: iss_en 1..TAPS cycles after acceptance, res_valid TAPS+MULT_LAT+1 cycles after.
// Backpressure: res_valid held until res_ready; req_ready only in IDLE (requests not queued).
module dct_mac_sequencer
    import jpeg_dct_pkg::*;
#(
    parameter int TAPS     = DCT_TAPS,
    parameter int MULT_LAT = DCT_MULT_LAT,
    parameter int ROW_W    = DCT_ROW_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    dct_mac_sequencer_if.slave  bus
);

    localparam int TAP_W = $clog2(TAPS);
    localparam int DRN_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAPS - 1);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(MULT_LAT - 1);

    seq_state_e       state_q, state_d;
    logic [TAP_W-1:0] tap_q, tap_d;
    logic [DRN_W-1:0] drain_q, drain_d;
    logic [ROW_W-1:0] row_q, row_d;
    strobe_t          stb_in, stb_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tap_q   <= '0;
            drain_q <= '0;
            row_q   <= '0;
        end else if (ena) begin
            state_q <= state_d;
            tap_q   <= tap_d;
            drain_q <= drain_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        drain_d = drain_q;
        row_d   = row_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    state_d = ISSUE;
                    tap_d   = '0;
                    row_d   = bus.req_row;
                end
            end
            ISSUE: begin
                if (tap_q == TAP_LAST) begin
                    state_d = DRAIN;
                    tap_d   = '0;
                    drain_d = '0;
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            // Wait until the final tap's strobe has left the delay line.
            DRAIN: begin
                if (drain_q == DRN_LAST) begin
                    state_d = HOLD;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            HOLD: begin
                if (bus.res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.iss_en    = (state_q == ISSUE);
    assign bus.iss_tap   = tap_q;
    assign bus.coef_addr = {row_q, tap_q};
    assign bus.res_valid = (state_q == HOLD);
    assign bus.busy      = (state_q != IDLE);

    assign stb_in.en  = bus.iss_en;
    assign stb_in.clr = bus.iss_en && (tap_q == '0);

    dct_strobe_delay #(.DEPTH(MULT_LAT)) u_strobe_delay (
        .clk  (clk),
        .clr  (rst),
        .ena  (ena),
        .din  (stb_in),
        .dout (stb_out)
    );

    assign bus.acc_en  = stb_out.en;
    assign bus.acc_clr = stb_out.en && stb_out.clr;

endmodule

// File: tb/tb_dct_mac_sequencer.sv
// Bench for dct_mac_sequencer: three builds (MULT_LAT 2,1,4) share one stimulus stream;
// a negedge monitor pops expected issue/accumulate events pushed at request acceptance.
module tb_dct_mac_sequencer;
    import jpeg_dct_pkg::*;

    localparam int TAPS  = DCT_TAPS;
    localparam int ROW_W = DCT_ROW_W;
    localparam int TAP_W = $clog2(TAPS);
    localparam int NI    = 3;

    typedef struct { int gc; int addr; int tap; } iss_t;
    typedef struct { int gc; bit clr; } acc_t;

    logic             clk;
    logic             rst, ena, req_valid, res_ready;
    logic [ROW_W-1:0] req_row;
    logic             win_on, done;

    logic                   o_req_ready [NI];
    logic                   o_iss_en    [NI];
    logic                   o_acc_en    [NI];
    logic                   o_acc_clr   [NI];
    logic                   o_res_valid [NI];
    logic                   o_busy      [NI];
    logic [TAP_W-1:0]       o_iss_tap   [NI];
    logic [ROW_W+TAP_W-1:0] o_coef_addr [NI];

    dct_mac_sequencer_if #(.TAPS(TAPS), .ROW_W(ROW_W)) bus [NI] ();

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : 4;
        dct_mac_sequencer #(.TAPS(TAPS), .MULT_LAT(LAT), .ROW_W(ROW_W)) u_dut (
            .clk (clk),
            .rst (rst),
            .ena (ena),
            .bus (bus[g])
        );
        assign bus[g].req_valid = req_valid;
        assign bus[g].req_row   = req_row;
        assign bus[g].res_ready = res_ready;
        assign o_req_ready[g]   = bus[g].req_ready;
        assign o_iss_en[g]      = bus[g].iss_en;
        assign o_iss_tap[g]     = bus[g].iss_tap;
        assign o_coef_addr[g]   = bus[g].coef_addr;
        assign o_acc_en[g]      = bus[g].acc_en;
        assign o_acc_clr[g]     = bus[g].acc_clr;
        assign o_res_valid[g]   = bus[g].res_valid;
        assign o_busy[g]        = bus[g].busy;
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : (i == 1) ? 1 : 4;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard state, owned by the monitor process.
    iss_t iss_q [NI][$];
    acc_t acc_q [NI][$];
    bit   m_idle   [NI];
    int   m_res_gc [NI];
    int   gcnt;
    int   checks;
    int   errors;

    task automatic chk(input string name, input int inst, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s inst%0d gc=%0d got %0d want %0d", name, inst, gcnt, act, exp);
        end
    endtask

    initial begin : monitor
        iss_t ie;
        acc_t ae;
        bit   e_iss, e_acc, e_clr, e_res;
        bit   prev_win;
        int   rcnt, w_acc, w_clr, w_acc_rc, w_res_rc;
        int   w_hits [TAPS];

        gcnt = 0; checks = 0; errors = 0; rcnt = 0;
        prev_win = 1'b0; w_acc = 0; w_clr = 0; w_acc_rc = -1; w_res_rc = -1;
        for (int t = 0; t < TAPS; t++) w_hits[t] = 0;
        for (int i = 0; i < NI; i++) begin m_idle[i] = 1'b1; m_res_gc[i] = 0; end

        forever begin
            @(negedge clk);
            rcnt++;
            if (done) begin
                for (int i = 0; i < NI; i++)
                    chk("leftover_events", i, iss_q[i].size() + acc_q[i].size(), 0);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end

            // ena-toggling window: tally instance 0 strobes and result timing.
            if (win_on) begin
                if (!rst && ena) begin
                    if (o_acc_en[0])  w_acc++;
                    if (o_acc_clr[0]) w_clr++;
                    if (o_iss_en[0])  w_hits[o_iss_tap[0]]++;
                end
                if (o_res_valid[0] && w_res_rc < 0) w_res_rc = rcnt;
            end else if (prev_win) begin
                chk("t4_acc_en_count", 0, w_acc, 8);
                chk("t4_acc_clr_count", 0, w_clr, 1);
                for (int t = 0; t < TAPS; t++) chk("t4_tap_once", t, w_hits[t], 1);
                chk("t4_res_cycles", 0, w_res_rc - w_acc_rc + 1, 22);
                w_acc = 0; w_clr = 0; w_acc_rc = -1; w_res_rc = -1;
                for (int t = 0; t < TAPS; t++) w_hits[t] = 0;
            end
            prev_win = win_on;

            if (rst) begin
                for (int i = 0; i < NI; i++) begin
                    iss_q[i].delete();
                    acc_q[i].delete();
                    m_idle[i] = 1'b1;
                end
            end else if (ena) begin
                for (int i = 0; i < NI; i++) begin
                    e_iss = (iss_q[i].size() > 0) && (iss_q[i][0].gc == gcnt);
                    chk("iss_en", i, int'(o_iss_en[i]), int'(e_iss));
                    if (e_iss) begin
                        ie = iss_q[i].pop_front();
                        if (o_iss_en[i]) begin
                            chk("coef_addr", i, int'(o_coef_addr[i]), ie.addr);
                            chk("iss_tap", i, int'(o_iss_tap[i]), ie.tap);
                        end
                    end

                    e_acc = (acc_q[i].size() > 0) && (acc_q[i][0].gc == gcnt);
                    e_clr = e_acc && acc_q[i][0].clr;
                    if (e_acc) ae = acc_q[i].pop_front();
                    chk("acc_en", i, int'(o_acc_en[i]), int'(e_acc));
                    chk("acc_clr", i, int'(o_acc_clr[i]), int'(e_clr));

                    e_res = !m_idle[i] && (gcnt >= m_res_gc[i]);
                    chk("req_ready", i, int'(o_req_ready[i]), int'(m_idle[i]));
                    chk("busy", i, int'(o_busy[i]), int'(!m_idle[i]));
                    chk("res_valid", i, int'(o_res_valid[i]), int'(e_res));

                    if (m_idle[i]) begin
                        if (req_valid) begin
                            for (int t = 0; t < TAPS; t++) begin
                                ie.gc = gcnt + 1 + t; ie.addr = int'(req_row) * TAPS + t; ie.tap = t;
                                iss_q[i].push_back(ie);
                                ae.gc = gcnt + 1 + lat_of(i) + t; ae.clr = (t == 0);
                                acc_q[i].push_back(ae);
                            end
                            m_res_gc[i] = gcnt + TAPS + lat_of(i) + 1;
                            m_idle[i]   = 1'b0;
                            if (i == 0 && win_on) w_acc_rc = rcnt;
                        end
                    end else if (e_res && res_ready) begin
                        m_idle[i] = 1'b1;
                    end
                end
                gcnt++;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : driver
        rst = 1'b1; ena = 1'b1; req_valid = 1'b0; req_row = '0; res_ready = 1'b1;
        win_on = 1'b0; done = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(3);

        // Single request, row 5, result consumed immediately.
        req_valid = 1'b1; req_row = 3'd5;
        cyc(1);
        req_valid = 1'b0;
        cyc(20);

        // Result backpressure with ignored requests while busy.
        res_ready = 1'b0; req_valid = 1'b1; req_row = 3'd3;
        cyc(1);
        req_valid = 1'b0;
        cyc(20);
        req_valid = 1'b1; req_row = 3'd6;
        cyc(3);
        req_valid = 1'b0;
        cyc(20);
        res_ready = 1'b1;
        cyc(5);

        // ena toggled every cycle across a row-2 request.
        win_on = 1'b1; req_valid = 1'b1; req_row = 3'd2;
        cyc(1);
        req_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            ena = (k % 2 == 0);
            cyc(1);
        end
        ena = 1'b1;
        cyc(10);
        win_on = 1'b0;
        cyc(3);

        // Reset mid-issue (tap 4 on the default build), then a clean row-1 request.
        req_valid = 1'b1; req_row = 3'd7;
        cyc(1);
        req_valid = 1'b0;
        cyc(4);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(5);
        req_valid = 1'b1; req_row = 3'd1;
        cyc(1);
        req_valid = 1'b0;
        cyc(20);

        // Back-to-back requests with req_valid held high and a changing row.
        req_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            req_row = ROW_W'(k);
            cyc(1);
        end
        req_valid = 1'b0;
        cyc(30);

        done = 1'b1;
        cyc(5);
    end

endmodule
